// File: rtl/cache_pkg.sv
// Shared widths, FSM encoding and word-select helper for the direct-mapped read cache.
package cache_pkg;
   localparam int ADDR_W     = 15;
   localparam int TAG_W      = 3;
   localparam int INDEX_W    = 10;
   localparam int OFFSET_W   = 2;
   localparam int WORD_W     = 32;
   localparam int BLOCK_W    = 128;
   localparam int MEM_ADDR_W = 13;
   localparam int LINES      = 1 << INDEX_W;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMPARE  = 2'd1,
      ALLOCATE = 2'd2
   } state_t;

   // Offset 0 is the least significant word of the block.
   function automatic logic [WORD_W-1:0] selectWord(input logic [BLOCK_W-1:0] blk,
                                                    input logic [OFFSET_W-1:0] off);
      return blk[off*WORD_W +: WORD_W];
   endfunction
endpackage

// File: rtl/cache_tag_memory.sv
// Tag array and valid vector: combinational read, synchronous write; rst clears valid bits only.
module cache_tag_memory
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rdIndex,
   output logic [TAG_W-1:0]   rdTag,
   output logic               rdValid,
   input  logic               wrEn,
   input  logic [INDEX_W-1:0] wrIndex,
   input  logic [TAG_W-1:0]   wrTag
);
   logic [TAG_W-1:0] tagArr [LINES];
   logic [LINES-1:0] validBits;

   assign rdTag   = tagArr[rdIndex];
   assign rdValid = validBits[rdIndex];

   // Tag contents deliberately survive reset; the valid bits gate them.
   always_ff @(posedge clk) begin
      if (wrEn) tagArr[wrIndex] <= wrTag;
   end

   always_ff @(posedge clk) begin
      if (rst)       validBits          <= '0;
      else if (wrEn) validBits[wrIndex] <= 1'b1;
   end
endmodule

// File: rtl/cache_controller.sv
// Read-path controller: IDLE -> COMPARE -> (hit) IDLE, or -> ALLOCATE -> replay COMPARE.
module cache_controller
   import cache_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpuRdEn,
   input  logic [ADDR_W-1:0]     cpuAddress,
   output logic [WORD_W-1:0]     cpuData,
   output logic                  cpuReady,
   output logic                  memRdEn,
   output logic [MEM_ADDR_W-1:0] memAddress,
   input  logic [BLOCK_W-1:0]    memData,
   input  logic                  memReady,
   output logic                  dataWrEn,
   output logic [INDEX_W-1:0]    dataAddress,
   output logic [BLOCK_W-1:0]    dataIn,
   input  logic [BLOCK_W-1:0]    dataOut,
   output logic [COUNT_W-1:0]    hitCount,
   output logic [COUNT_W-1:0]    missCount
);
   state_t               state;
   logic [TAG_W-1:0]     reqTag;
   logic [INDEX_W-1:0]   reqIndex;
   logic [OFFSET_W-1:0]  reqOffset;
   logic                 replay;
   logic [TAG_W-1:0]     lineTag;
   logic                 lineValid;
   logic                 hit;

   cache_tag_memory tagMem (
      .clk     (clk),
      .rst     (rst),
      .rdIndex (reqIndex),
      .rdTag   (lineTag),
      .rdValid (lineValid),
      .wrEn    (dataWrEn),
      .wrIndex (reqIndex),
      .wrTag   (reqTag)
   );

   assign hit         = lineValid && (lineTag == reqTag);
   assign memRdEn     = (state == ALLOCATE);
   assign memAddress  = {reqTag, reqIndex};
   assign dataAddress = reqIndex;
   assign dataIn      = memData;
   assign dataWrEn    = (state == ALLOCATE) && memReady;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         reqTag    <= '0;
         reqIndex  <= '0;
         reqOffset <= '0;
         cpuData   <= '0;
         cpuReady  <= 1'b0;
         hitCount  <= '0;
         missCount <= '0;
         replay    <= 1'b0;
      end else begin
         cpuReady <= 1'b0;
         case (state)
            IDLE: begin
               // The cycle after a completion is skipped so a held request is not re-served early.
               if (cpuRdEn && !cpuReady) begin
                  reqTag    <= cpuAddress[ADDR_W-1 -: TAG_W];
                  reqIndex  <= cpuAddress[OFFSET_W +: INDEX_W];
                  reqOffset <= cpuAddress[OFFSET_W-1:0];
                  state     <= COMPARE;
               end
            end
            COMPARE: begin
               replay <= 1'b0;
               if (hit) begin
                  cpuData  <= selectWord(dataOut, reqOffset);
                  cpuReady <= 1'b1;
                  if (!replay) hitCount <= hitCount + 1'b1;
                  state    <= IDLE;
               end else begin
                  missCount <= missCount + 1'b1;
                  state     <= ALLOCATE;
               end
            end
            ALLOCATE: begin
               if (memReady) begin
                  replay <= 1'b1;
                  state  <= COMPARE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
